// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data memory arbiter with RV32I load/store
// alignment, lane extraction and fault detection; one access per three cycles.
module dmem_arbiter #(
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [2:0]    r0_funct3,
    input  logic [31:0]   r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [31:0]   r0_rdata,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [2:0]    r1_funct3,
    input  logic [31:0]   r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [31:0]   r1_rdata,
    output logic          r1_err,
    output logic [AW-1:0] mem_rd_addr,
    output logic [AW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_din,
    output logic          mem_we,
    output logic [2:0]    mem_wr_strb,
    input  logic [31:0]   mem_rd_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_q;
    logic        own_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        gnt_any;
    logic        pick;
    logic        fault;
    logic        in_access;
    logic        in_resp;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] load_val;

    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
    assign gnt_any   = rst && (state == IDLE) && (r0_req || r1_req);
    assign pick      = (r0_req && r1_req) ? ~last_q : r1_req;
    assign r0_gnt    = gnt_any && !pick;
    assign r1_gnt    = gnt_any && pick;
    assign in_access = rst && (state == ACCESS);
    assign in_resp   = rst && (state == RESP);

    always_comb begin
        fault = 1'b0;
        case (f3_q)
            3'd3, 3'd6, 3'd7: fault = 1'b1;
            3'd1, 3'd5:       fault = addr_q[0];
            3'd2:             fault = |addr_q[1:0];
            default:          fault = 1'b0;
        endcase
        if ((addr_q >> (AW + 2)) != '0)
            fault = 1'b1;
    end

    assign shifted = mem_rd_dout >> {addr_q[1:0], 3'b000};
    assign half    = addr_q[1] ? mem_rd_dout[31:16] : mem_rd_dout[15:0];

    always_comb begin
        load_val = '0;
        case (f3_q)
            3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    load_val = {24'b0, shifted[7:0]};
            3'd1:    load_val = {{16{half[15]}}, half};
            3'd5:    load_val = {16'b0, half};
            3'd2:    load_val = mem_rd_dout;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_any) begin
                last_q  <= pick;
                own_q   <= pick;
                we_q    <= pick ? r1_we     : r0_we;
                addr_q  <= pick ? r1_addr   : r0_addr;
                f3_q    <= pick ? r1_funct3 : r0_funct3;
                wdata_q <= pick ? r1_wdata  : r0_wdata;
            end
            if (state == ACCESS)
                rdata_q <= (!we_q && !fault) ? load_val : '0;
        end
    end

    assign mem_rd_addr = in_access ? addr_q[AW+1:2] : '0;
    assign mem_wr_addr = in_access ? addr_q[AW+1:2] : '0;
    assign mem_we      = in_access && we_q && !fault;

    always_comb begin
        mem_wr_strb = 3'b010;
        mem_wr_din  = '0;
        if (mem_we) begin
            case (f3_q[1:0])
                2'd0: begin
                    mem_wr_strb = {1'b1, addr_q[1:0]};
                    mem_wr_din  = {24'b0, wdata_q[7:0]};
                end
                2'd1: begin
                    mem_wr_strb = {1'b0, addr_q[1], 1'b1};
                    mem_wr_din  = {16'b0, wdata_q[15:0]};
                end
                default: begin
                    mem_wr_strb = 3'b000;
                    mem_wr_din  = wdata_q;
                end
            endcase
        end
    end

    assign r0_rvalid = in_resp && !own_q;
    assign r1_rvalid = in_resp && own_q;
    assign r0_err    = r0_rvalid && fault;
    assign r1_err    = r1_rvalid && fault;
    assign r0_rdata  = r0_rvalid ? rdata_q : '0;
    assign r1_rdata  = r1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural word memory
// honouring the store-mode strobes.
module tb_dmem_arbiter;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk;
    logic          rst;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [31:0]   r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [2:0]    r0_funct3, r1_funct3;
    logic          r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0]   r0_rdata, r1_rdata;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [31:0]   mem_wr_din, mem_rd_dout;
    logic          mem_we;
    logic [2:0]    mem_wr_strb;

    logic [31:0]   mem [DEPTH];
    int            checks = 0;
    int            errors = 0;

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_funct3(r0_funct3),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_funct3(r1_funct3),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_wr_din(mem_wr_din), .mem_we(mem_we), .mem_wr_strb(mem_wr_strb),
        .mem_rd_dout(mem_rd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_dout = mem[mem_rd_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_wr_strb)
                3'b000: mem[mem_wr_addr] <= mem_wr_din;
                3'b001: mem[mem_wr_addr][15:0]  <= mem_wr_din[15:0];
                3'b011: mem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
                3'b100: mem[mem_wr_addr][7:0]   <= mem_wr_din[7:0];
                3'b101: mem[mem_wr_addr][15:8]  <= mem_wr_din[7:0];
                3'b110: mem[mem_wr_addr][23:16] <= mem_wr_din[7:0];
                3'b111: mem[mem_wr_addr][31:24] <= mem_wr_din[7:0];
                default: ;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int rid, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic exp_we, input logic [2:0] exp_strb,
                          input logic [31:0] exp_din, input logic [31:0] exp_rdata,
                          input logic exp_err);
        if (rid == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_funct3 = f3; r0_wdata = wd;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_funct3 = f3; r1_wdata = wd;
        end
        #1;
        chk("gnt0", {31'b0, r0_gnt}, (rid == 0) ? 32'd1 : 32'd0);
        chk("gnt1", {31'b0, r1_gnt}, (rid == 1) ? 32'd1 : 32'd0);
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        r0_wdata = '0; r1_wdata = '0; r0_addr = '0; r1_addr = '0;
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        chk("rd_addr", {25'b0, mem_rd_addr}, (addr >> 2) & 32'h7F);
        chk("wr_addr", {25'b0, mem_wr_addr}, (addr >> 2) & 32'h7F);
        if (exp_we) begin
            chk("strb", {29'b0, mem_wr_strb}, {29'b0, exp_strb});
            chk("din", mem_wr_din, exp_din);
        end
        step();
        chk("rvalid0", {31'b0, r0_rvalid}, (rid == 0) ? 32'd1 : 32'd0);
        chk("rvalid1", {31'b0, r1_rvalid}, (rid == 1) ? 32'd1 : 32'd0);
        chk("rdata", (rid == 0) ? r0_rdata : r1_rdata, exp_rdata);
        chk("err", {31'b0, (rid == 0) ? r0_err : r1_err}, {31'b0, exp_err});
        step();
        chk("idle_strb", {29'b0, mem_wr_strb}, 32'd2);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"}, {30'b0, r0_gnt, r1_gnt}, 32'd0);
        chk({tag, "_rvalid"}, {30'b0, r0_rvalid, r1_rvalid}, 32'd0);
        chk({tag, "_err"}, {30'b0, r0_err, r1_err}, 32'd0);
        chk({tag, "_rdata"}, r0_rdata | r1_rdata, 32'd0);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"}, {18'b0, mem_rd_addr, mem_wr_addr}, 32'd0);
        chk({tag, "_strb"}, {29'b0, mem_wr_strb}, 32'd2);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_funct3 = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_funct3 = '0; r1_wdata = '0;
        step();
        r0_req = 1'b1; r1_req = 1'b1;
        step();
        check_quiet("reset");
        r0_req = 1'b0; r1_req = 1'b0;
        rst = 1'b1;
        #1;
        check_quiet("post_reset");

        // SW / LW round trip
        access(0, 1'b1, 32'h8, 3'd2, 32'hDEADBEEF, 1'b1, 3'b000, 32'hDEADBEEF, 32'h0, 1'b0);
        access(0, 1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Sub-word loads from 0x80FF7F01
        access(0, 1'b1, 32'h8, 3'd2, 32'h80FF7F01, 1'b1, 3'b000, 32'h80FF7F01, 32'h0, 1'b0);
        access(0, 1'b0, 32'hB, 3'd0, 32'h0, 1'b0, 3'b010, 32'h0, 32'hFFFFFF80, 1'b0);
        access(1, 1'b0, 32'hB, 3'd4, 32'h0, 1'b0, 3'b010, 32'h0, 32'h00000080, 1'b0);
        access(0, 1'b0, 32'hA, 3'd1, 32'h0, 1'b0, 3'b010, 32'h0, 32'hFFFF80FF, 1'b0);
        access(1, 1'b0, 32'h8, 3'd5, 32'h0, 1'b0, 3'b010, 32'h0, 32'h00007F01, 1'b0);

        // Sub-word stores; word 2 becomes 0x1234AA01
        access(0, 1'b1, 32'h9, 3'd0, 32'h123456AA, 1'b1, 3'b101, 32'h000000AA, 32'h0, 1'b0);
        access(1, 1'b1, 32'hA, 3'd1, 32'hCAFE1234, 1'b1, 3'b011, 32'h00001234, 32'h0, 1'b0);
        access(1, 1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 3'b010, 32'h0, 32'h1234AA01, 1'b0);

        // Faults
        access(0, 1'b1, 32'h6, 3'd2, 32'h11111111, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        access(1, 1'b0, 32'h3, 3'd1, 32'h0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        access(0, 1'b0, 32'h8, 3'd3, 32'h0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        access(1, 1'b0, 32'h200, 3'd2, 32'h0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        access(0, 1'b1, 32'h200, 3'd2, 32'h22222222, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        access(0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

        // Highest in-range word
        access(1, 1'b1, 32'h1FC, 3'd2, 32'hA5A50F0F, 1'b1, 3'b000, 32'hA5A50F0F, 32'h0, 1'b0);
        access(0, 1'b0, 32'h1FC, 3'd2, 32'h0, 1'b0, 3'b010, 32'h0, 32'hA5A50F0F, 1'b0);

        // Round robin with both requests held after a fresh reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h8; r0_funct3 = 3'd2;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h1FC; r1_funct3 = 3'd2;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt0", {31'b0, r0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", {31'b0, r1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            chk("rr_access_gnt", {30'b0, r0_gnt, r1_gnt}, 32'd0);
            step();
            chk("rr_resp_gnt", {30'b0, r0_gnt, r1_gnt}, 32'd0);
            chk("rr_rvalid", {30'b0, r1_rvalid, r0_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_rdata", (k % 2 == 0) ? r0_rdata : r1_rdata,
                (k % 2 == 0) ? 32'h1234AA01 : 32'hA5A50F0F);
            step();
        end
        r0_req = 1'b0; r1_req = 1'b0;

        // Reset during the ACCESS of a store aborts it
        access(0, 1'b1, 32'h10, 3'd2, 32'h11111111, 1'b1, 3'b000, 32'h11111111, 32'h0, 1'b0);
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h10; r0_funct3 = 3'd2; r0_wdata = 32'h55;
        #1;
        chk("abort_gnt", {31'b0, r0_gnt}, 32'd1);
        step();
        r0_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_we", {31'b0, mem_we}, 32'd0);
        step();
        check_quiet("abort1");
        step();
        check_quiet("abort2");
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10; r0_funct3 = 3'd2;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h0; r1_funct3 = 3'd2;
        #1;
        chk("tie_gnt0", {31'b0, r0_gnt}, 32'd1);
        chk("tie_gnt1", {31'b0, r1_gnt}, 32'd0);
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        step();
        chk("abort_rvalid", {31'b0, r0_rvalid}, 32'd1);
        chk("abort_mem", r0_rdata, 32'h11111111);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
